// File: rtl/multi_channel_synchronizer.sv
// WIDTH independent async flags: N-stage synchronizer, per-channel stability filter,
// registered rise/fall strobes and sticky event flags with per-channel clear.
module multi_channel_synchronizer #(
   parameter int               WIDTH      = 8,
   parameter int               STAGES     = 2,
   parameter int               FILTER_LEN = 4,
   parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [WIDTH-1:0] IN,
   input  logic [WIDTH-1:0] CLEAR,
   output logic [WIDTH-1:0] OUT,
   output logic [WIDTH-1:0] RISE,
   output logic [WIDTH-1:0] FALL,
   output logic [WIDTH-1:0] EVENT,
   output logic             EVENT_ANY
);

   localparam int               CNT_W    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_chan
         logic [STAGES-1:0] sync_reg;
         logic [CNT_W-1:0]  cnt_reg;
         logic [CNT_W-1:0]  cnt_next;
         logic              out_reg;
         logic              out_next;
         logic              rise_reg;
         logic              rise_next;
         logic              fall_reg;
         logic              fall_next;
         logic              event_reg;
         logic              event_next;
         logic              sync_s;

         // Plain shift chain: nothing may sit between metastability-resolving stages.
         always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
               sync_reg <= {STAGES{INIT_VALUE[gi]}};
            end else begin
               sync_reg <= {sync_reg[STAGES-2:0], IN[gi]};
            end
         end

         assign sync_s = sync_reg[STAGES-1];

         // OUT only follows after FILTER_LEN consecutive disagreeing samples.
         always_comb begin
            cnt_next  = '0;
            out_next  = out_reg;
            rise_next = 1'b0;
            fall_next = 1'b0;
            if (sync_s != out_reg) begin
               if (cnt_reg == CNT_LAST) begin
                  out_next  = sync_s;
                  rise_next = sync_s;
                  fall_next = ~sync_s;
               end else begin
                  cnt_next = cnt_reg + CNT_W'(1);
               end
            end
            event_next = (event_reg & ~CLEAR[gi]) | rise_next | fall_next;
         end

         always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
               cnt_reg   <= '0;
               out_reg   <= INIT_VALUE[gi];
               rise_reg  <= 1'b0;
               fall_reg  <= 1'b0;
               event_reg <= 1'b0;
            end else begin
               cnt_reg   <= cnt_next;
               out_reg   <= out_next;
               rise_reg  <= rise_next;
               fall_reg  <= fall_next;
               event_reg <= event_next;
            end
         end

         assign OUT[gi]   = out_reg;
         assign RISE[gi]  = rise_reg;
         assign FALL[gi]  = fall_reg;
         assign EVENT[gi] = event_reg;
      end
   endgenerate

   assign EVENT_ANY = |EVENT;

endmodule

// File: tb/tb_multi_channel_synchronizer.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based model.
module tb_multi_channel_synchronizer;

   localparam int W = 4;
   localparam int S = 2;
   localparam int F = 3;

   logic         clk;
   logic         rst_n, rst2_n;
   logic [W-1:0] din, clr, dout, rise, fall, evt;
   logic         evt_any;
   logic [W-1:0] din2, clr2, dout2, rise2, fall2, evt2;
   logic         evt_any2;

   int checks = 0;
   int errors = 0;

   multi_channel_synchronizer #(
      .WIDTH(W), .STAGES(S), .FILTER_LEN(F), .INIT_VALUE(4'h0)
   ) dut (
      .CLK(clk), .RST_N(rst_n), .IN(din), .CLEAR(clr),
      .OUT(dout), .RISE(rise), .FALL(fall), .EVENT(evt), .EVENT_ANY(evt_any)
   );

   multi_channel_synchronizer #(
      .WIDTH(W), .STAGES(3), .FILTER_LEN(1), .INIT_VALUE(4'hF)
   ) dut2 (
      .CLK(clk), .RST_N(rst2_n), .IN(din2), .CLEAR(clr2),
      .OUT(dout2), .RISE(rise2), .FALL(fall2), .EVENT(evt2), .EVENT_ANY(evt_any2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Reference model: IN seen through an S-sample delay line; OUT adopts the delayed value
   // once it has disagreed with OUT for F consecutive clocks.
   logic [W-1:0] m_dly[$];
   logic [W-1:0] m_s, m_out, m_rise, m_fall, m_event;
   int           m_run[W];

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_dly = {};
            for (int i = 0; i < S; i++) m_dly.push_back('0);
            m_out = '0; m_rise = '0; m_fall = '0; m_event = '0;
            for (int i = 0; i < W; i++) m_run[i] = 0;
         end else begin
            m_s = m_dly.pop_front();
            m_dly.push_back(din);
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < W; i++) begin
               if (m_s[i] !== m_out[i]) begin
                  m_run[i] = m_run[i] + 1;
                  if (m_run[i] == F) begin
                     m_out[i] = m_s[i];
                     if (m_s[i]) m_rise[i] = 1'b1;
                     else        m_fall[i] = 1'b1;
                     m_run[i] = 0;
                  end
               end else begin
                  m_run[i] = 0;
               end
            end
            m_event = (m_event & ~clr) | m_rise | m_fall;
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; rst2_n = 1'b0;
      din = '0; clr = '0; din2 = 4'hF; clr2 = '0;
      repeat (3) tick;
      checks++;
      if ({dout, rise, fall, evt, evt_any} !== 17'h0) begin
         errors++;
         $display("FAIL reset_state: got %h required 0", {dout, rise, fall, evt, evt_any});
      end
      checks++;
      if ({dout2, rise2, fall2, evt2, evt_any2} !== {4'hF, 13'h0}) begin
         errors++;
         $display("FAIL reset_init_value: got %h required %h", {dout2, rise2, fall2, evt2, evt_any2}, {4'hF, 13'h0});
      end
      rst_n = 1'b1; rst2_n = 1'b1;
      repeat (3) tick;
      checks++;
      if ({dout, rise, fall, evt, evt_any} !== 17'h0 || {dout2, rise2, fall2, evt2, evt_any2} !== {4'hF, 13'h0}) begin
         errors++;
         $display("FAIL reset_exit: got %h / %h required 0 / %h", {dout, rise, fall, evt, evt_any},
                  {dout2, rise2, fall2, evt2, evt_any2}, {4'hF, 13'h0});
      end
      $display("test_reset: done");
   endtask

   task automatic test_rise;
      logic o, r;
      din = 4'b0001;
      for (int k = 1; k <= 6; k++) begin
         tick;
         o = (k >= 5);
         r = (k == 5);
         checks++;
         if ({dout[0], rise[0], evt[0], evt_any} !== {o, r, o, o}) begin
            errors++;
            $display("FAIL rise_latency edge %0d: out/rise/evt/any=%b required %b", k,
                     {dout[0], rise[0], evt[0], evt_any}, {o, r, o, o});
         end
      end
      $display("test_rise: done");
   endtask

   task automatic test_glitch;
      din = 4'b0011;
      tick; tick;
      din = 4'b0001;
      for (int k = 1; k <= 6; k++) begin
         tick;
         checks++;
         if ({dout[1], rise[1], evt[1]} !== 3'b000) begin
            errors++;
            $display("FAIL glitch_filtered edge %0d: out/rise/evt=%b required 000", k, {dout[1], rise[1], evt[1]});
         end
      end
      $display("test_glitch: done");
   endtask

   task automatic test_clear;
      clr = 4'b0001;
      tick;
      clr = '0;
      checks++;
      if ({evt, evt_any} !== 5'b0) begin
         errors++;
         $display("FAIL clear_event: evt/any=%b required 00000", {evt, evt_any});
      end
      din = 4'b0000;
      for (int k = 1; k <= 5; k++) begin
         if (k == 5) clr = 4'b0001;
         tick;
         checks++;
         if ({fall[0], evt[0]} !== ((k == 5) ? 2'b11 : 2'b00)) begin
            errors++;
            $display("FAIL clear_vs_fall edge %0d: fall/evt=%b required %b", k, {fall[0], evt[0]},
                     (k == 5) ? 2'b11 : 2'b00);
         end
      end
      clr = '0;
      tick;
      checks++;
      if ({fall[0], evt[0], evt_any} !== 3'b011) begin
         errors++;
         $display("FAIL event_sticky: fall/evt/any=%b required 011", {fall[0], evt[0], evt_any});
      end
      $display("test_clear: done");
   endtask

   task automatic test_reset_mid;
      din = 4'hC;
      repeat (6) tick;
      checks++;
      if (dout !== 4'hC) begin
         errors++;
         $display("FAIL pre_reset_out: got %h required c", dout);
      end
      din = 4'hF;
      tick; tick;
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if ({dout, rise, fall, evt, evt_any} !== 17'h0) begin
         errors++;
         $display("FAIL async_reset: got %h required 0", {dout, rise, fall, evt, evt_any});
      end
      tick;
      rst_n = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick;
         checks++;
         if ({dout, rise} !== ((k == 5) ? 8'hFF : 8'h00)) begin
            errors++;
            $display("FAIL reset_release_latency edge %0d: out/rise=%h required %h", k, {dout, rise},
                     (k == 5) ? 8'hFF : 8'h00);
         end
      end
      $display("test_reset_mid: done");
   endtask

   task automatic test_simultaneous;
      din = 4'h0;
      for (int k = 1; k <= 5; k++) begin
         tick;
         checks++;
         if ({rise, fall} !== ((k == 5) ? 8'h0F : 8'h00)) begin
            errors++;
            $display("FAIL all_fall edge %0d: rise/fall=%h required %h", k, {rise, fall}, (k == 5) ? 8'h0F : 8'h00);
         end
      end
      din = 4'hF;
      for (int k = 1; k <= 6; k++) begin
         tick;
         checks++;
         if ({rise, fall} !== ((k == 5) ? 8'hF0 : 8'h00)) begin
            errors++;
            $display("FAIL all_rise edge %0d: rise/fall=%h required %h", k, {rise, fall}, (k == 5) ? 8'hF0 : 8'h00);
         end
      end
      $display("test_simultaneous: done");
   endtask

   task automatic test_random;
      int bad = 0;
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < W; i++) begin
            if ($urandom_range(0, 5) == 0) din[i] = ~din[i];
            clr[i] = ($urandom_range(0, 7) == 0);
         end
         tick;
         checks++;
         if ({dout, rise, fall, evt, evt_any} !== {m_out, m_rise, m_fall, m_event, |m_event}) begin
            errors++;
            bad++;
            $display("FAIL random cycle %0d: out/rise/fall/evt/any=%h required %h", n,
                     {dout, rise, fall, evt, evt_any}, {m_out, m_rise, m_fall, m_event, |m_event});
         end
      end
      clr = '0;
      $display("test_random: 400 cycles, %0d mismatching", bad);
   endtask

   task automatic test_params;
      din2 = 4'b1011;
      for (int k = 1; k <= 5; k++) begin
         tick;
         checks++;
         if ({dout2[2], fall2[2], rise2, evt2[2], evt_any2} !== {(k < 4), (k == 4), 4'b0000, (k >= 4), (k >= 4)}) begin
            errors++;
            $display("FAIL stages3_filter1 edge %0d: out/fall/rise/evt/any=%b required %b", k,
                     {dout2[2], fall2[2], rise2, evt2[2], evt_any2},
                     {(k < 4), (k == 4), 4'b0000, (k >= 4), (k >= 4)});
         end
      end
      $display("test_params: done");
   endtask

   initial begin
      test_reset;
      test_rise;
      test_glitch;
      test_clear;
      test_reset_mid;
      test_simultaneous;
      test_random;
      test_params;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
